// File: rtl/fft_ram_writer.sv
// Write side of the FFT frame buffer. Takes one N-point FFT output frame
// as a streaming sink, writes bin k as {real,imag} to RAM address k, then
// raises fftdone and holds off new frames until the detector releases the
// buffer with detectdone. Frames that arrive while the detector owns the
// buffer are dropped and counted.
module fft_ram_writer #(
    parameter int N  = 1024,
    parameter int AW = 10,
    parameter int DW = 14
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sink_valid,
    input  logic            sink_sop,
    input  logic            sink_eop,
    input  logic [DW-1:0]   sink_real,
    input  logic [DW-1:0]   sink_imag,
    output logic            sink_ready,
    output logic            wren,
    output logic [AW-1:0]   wraddr,
    output logic [2*DW-1:0] data,
    output logic            fftdone,
    input  logic            detectdone,
    output logic            frame_err,
    output logic [7:0]      drop_cnt
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t          state, state_n;
    logic [AW-1:0]   cnt, cnt_n;
    logic            wr_n;
    logic [AW-1:0]   wa_n;
    logic            err_set;
    logic            drop_inc;
    logic            acc;

    // Ready is gated by reset so it drops with the rest of the outputs
    // asynchronously; the buffer is closed to the FFT while it is DONE.
    assign sink_ready = reset && (state != DONE);
    assign acc        = sink_valid && sink_ready;

    // State and bin counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Frame tracking: decide per beat whether to write, where, and how the
    // frame ends (complete, malformed, or restarted by a fresh sop)
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        wr_n     = 1'b0;
        wa_n     = cnt;
        err_set  = 1'b0;
        drop_inc = 1'b0;
        case (state)
            IDLE: begin
                if (acc && sink_sop) begin
                    if (sink_eop) begin
                        // a one-beat frame cannot be a valid N-point frame
                        err_set = 1'b1;
                    end else begin
                        wr_n    = 1'b1;
                        wa_n    = '0;
                        cnt_n   = AW'(1);
                        state_n = FILL;
                    end
                end
            end
            FILL: begin
                if (acc) begin
                    if (sink_sop && sink_eop) begin
                        err_set = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else if (sink_sop) begin
                        // restart: this beat is bin 0 of a new frame
                        wr_n    = 1'b1;
                        wa_n    = '0;
                        cnt_n   = AW'(1);
                        err_set = 1'b1;
                    end else begin
                        wr_n = 1'b1;
                        wa_n = cnt;
                        if (sink_eop && cnt == LAST) begin
                            cnt_n   = '0;
                            state_n = DONE;
                        end else if (sink_eop || cnt == LAST) begin
                            // early eop, or last bin without eop
                            err_set = 1'b1;
                            cnt_n   = '0;
                            state_n = IDLE;
                        end else begin
                            cnt_n = cnt + AW'(1);
                        end
                    end
                end
            end
            DONE: begin
                if (sink_valid && sink_sop) drop_inc = 1'b1;
                // only release once the detector has actually seen fftdone
                if (fftdone && detectdone) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered write port: one cycle after the accepting edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wren   <= 1'b0;
            wraddr <= '0;
            data   <= '0;
        end else begin
            wren <= wr_n;
            if (wr_n) begin
                wraddr <= wa_n;
                data   <= {sink_real, sink_imag};
            end
        end
    end

    // fftdone trails DONE entry by one cycle so the last word is committed
    // before the detector reads; it drops together with the release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fftdone <= 1'b0;
        else        fftdone <= (state == DONE) && !(fftdone && detectdone);
    end

    // Sticky error flag and saturating drop counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (err_set) frame_err <= 1'b1;
            if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_fft_ram_writer.sv
// Bench for fft_ram_writer: a table of short IDLE/FILL corner vectors, then
// full frames checked by a write scoreboard (expected word = arrival index
// and payload of every accepted beat) plus a RAM image built from the port.
module tb_fft_ram_writer;

    localparam int N  = 1024;
    localparam int AW = 10;
    localparam int DW = 14;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
    logic [DW-1:0]   sink_real = '0, sink_imag = '0;
    logic            sink_ready, wren, fftdone, frame_err;
    logic            detectdone = 1'b0;
    logic [AW-1:0]   wraddr;
    logic [2*DW-1:0] data;
    logic [7:0]      drop_cnt;

    int vecs = 0;
    int errs = 0;
    bit mon_en = 1'b0;
    logic [AW+2*DW-1:0] exp_q[$];
    logic [2*DW-1:0]    mem [N];

    fft_ram_writer #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_real(sink_real), .sink_imag(sink_imag), .sink_ready(sink_ready),
        .wren(wren), .wraddr(wraddr), .data(data), .fftdone(fftdone),
        .detectdone(detectdone), .frame_err(frame_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // RAM image and write scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (reset && wren) begin
            mem[wraddr] = data;
            if (mon_en) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL wr_unexpected: got addr %0h data %0h, no write expected", wraddr, data);
                end else begin
                    logic [AW+2*DW-1:0] e;
                    e = exp_q.pop_front();
                    if ({wraddr, data} !== e) begin
                        errs++;
                        $display("FAIL wr_word: got %0h/%0h expected %0h/%0h",
                                 wraddr, data, e[AW+2*DW-1:2*DW], e[2*DW-1:0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one clock with the given beat on the bus; acc reports acceptance
    task automatic beat(input bit v, input bit s, input bit e,
                        input logic [DW-1:0] re, input logic [DW-1:0] im, output bit acc);
        sink_valid = v; sink_sop = s; sink_eop = e; sink_real = re; sink_imag = im;
        acc = v && sink_ready;
        @(posedge clk); #1;
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) beat(1'b0, 1'b0, 1'b0, '0, '0, acc);
    endtask

    task automatic send_frame(input int gapmax, input bit rnd, input int eop_at);
        bit acc;
        int g;
        logic [DW-1:0] kk, re, im;
        for (int k = 0; k < N; k++) begin
            g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            idle(g);
            kk = DW'(k);
            re = rnd ? DW'($urandom) : kk;
            im = rnd ? DW'($urandom) : ~kk;
            beat(1'b1, k == 0, k == eop_at, re, im, acc);
            if (acc && mon_en) exp_q.push_back({AW'(k), re, im});
            if (k == eop_at) break;
        end
    endtask

    // called right after the eop edge of a good frame
    task automatic check_done(input string tag);
        chk({tag, "_done_t1"}, fftdone, 0);
        chk({tag, "_wren_t1"}, wren, 1);
        @(posedge clk); #1;
        chk({tag, "_done_t2"}, fftdone, 1);
        chk({tag, "_ready_t2"}, sink_ready, 0);
        chk({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    task automatic release_buf();
        detectdone = 1'b1;
        @(posedge clk); #1;
        detectdone = 1'b0;
        chk("rel_done", fftdone, 0);
        chk("rel_ready", sink_ready, 1);
    endtask

    typedef struct {
        bit v, s, e;
        bit cw;               // check the write port on this row
        bit ew;
        logic [AW-1:0] ea;
        bit eerr;
    } vec_t;

    vec_t tbl[11];

    initial begin
        bit acc;
        logic [DW-1:0] re, im, a;

        //            v  s  e  cw ew ea  err
        tbl[0]  = '{0, 0, 0, 1, 0, 0, 0};  // idle
        tbl[1]  = '{1, 0, 0, 1, 0, 0, 0};  // non-sop beat in IDLE ignored
        tbl[2]  = '{1, 1, 1, 1, 0, 0, 1};  // sop+eop: malformed, no write
        tbl[3]  = '{1, 1, 0, 1, 1, 0, 1};  // frame start
        tbl[4]  = '{1, 0, 0, 1, 1, 1, 1};
        tbl[5]  = '{0, 0, 0, 1, 0, 0, 1};  // gap
        tbl[6]  = '{1, 0, 0, 1, 1, 2, 1};
        tbl[7]  = '{1, 1, 0, 1, 1, 0, 1};  // sop mid-frame restarts at 0
        tbl[8]  = '{1, 0, 0, 1, 1, 1, 1};
        tbl[9]  = '{1, 0, 1, 0, 0, 0, 1};  // early eop -> IDLE
        tbl[10] = '{1, 0, 0, 1, 0, 0, 1};  // back in IDLE: ignored

        // reset state, before any clock edge
        #3;
        chk("rst_ready", sink_ready, 0);
        chk("rst_wren", wren, 0);
        chk("rst_fftdone", fftdone, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_drop", drop_cnt, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("post_rst_ready", sink_ready, 1);
        @(posedge clk); #1;

        // table vectors
        for (int i = 0; i < 11; i++) begin
            re = DW'(i + 100);
            im = DW'(i * 37);
            beat(tbl[i].v, tbl[i].s, tbl[i].e, re, im, acc);
            if (tbl[i].cw) begin
                chk($sformatf("tbl%0d_wren", i), wren, tbl[i].ew);
                if (tbl[i].ew) begin
                    chk($sformatf("tbl%0d_addr", i), wraddr, tbl[i].ea);
                    chk($sformatf("tbl%0d_data", i), data, {re, im});
                end
            end
            chk($sformatf("tbl%0d_err", i), frame_err, tbl[i].eerr);
            chk($sformatf("tbl%0d_ready", i), sink_ready, 1);
            chk($sformatf("tbl%0d_done", i), fftdone, 0);
        end

        // asynchronous reset clears the sticky error without a clock
        #2 reset = 1'b0;
        #1 chk("arst_err", frame_err, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle(2);

        // 1) clean frame, real=k imag=~k
        mon_en = 1'b1;
        send_frame(0, 1'b0, N - 1);
        check_done("f1");
        a = 14'h0CC;
        chk("f1_mem_0cc", mem[10'h0CC], {a, ~a});
        a = 14'h3FF;
        chk("f1_mem_3ff", mem[10'h3FF], {a, ~a});

        // 3) frames arriving while DONE are dropped
        for (int f = 0; f < 3; f++) send_frame(1, 1'b1, N - 1);
        chk("drop3_cnt", drop_cnt, 3);
        chk("drop3_done", fftdone, 1);
        chk("drop3_q", exp_q.size(), 0);
        for (int f = 0; f < 252; f++) beat(1'b1, 1'b1, 1'b0, '0, '0, acc);
        chk("drop_255", drop_cnt, 255);
        beat(1'b1, 1'b1, 1'b0, '0, '0, acc);
        chk("drop_sat", drop_cnt, 255);
        chk("drop_done_held", fftdone, 1);

        // 2) + 6) release, then a random frame with random gaps
        release_buf();
        send_frame(3, 1'b1, N - 1);
        check_done("f2");
        chk("f2_err", frame_err, 0);

        // 4) early eop on beat 500
        release_buf();
        mon_en = 1'b0;
        send_frame(0, 1'b0, 500);
        idle(3);
        chk("bad_err", frame_err, 1);
        chk("bad_done", fftdone, 0);
        beat(1'b1, 1'b0, 1'b0, '0, '0, acc);
        chk("bad_idle_ign", wren, 0);
        mon_en = 1'b1;
        send_frame(2, 1'b1, N - 1);
        check_done("f4");
        chk("f4_err_sticky", frame_err, 1);

        // 5) reset mid-frame at beat 700
        release_buf();
        for (int k = 0; k < 700; k++) begin
            re = DW'($urandom); im = DW'($urandom);
            beat(1'b1, k == 0, 1'b0, re, im, acc);
            if (acc) exp_q.push_back({AW'(k), re, im});
        end
        #2 reset = 1'b0;
        #1;
        chk("mrst_wren", wren, 0);
        chk("mrst_addr", wraddr, 0);
        chk("mrst_data", data, 0);
        chk("mrst_ready", sink_ready, 0);
        chk("mrst_done", fftdone, 0);
        chk("mrst_err", frame_err, 0);
        chk("mrst_drop", drop_cnt, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        idle(1);
        send_frame(3, 1'b1, N - 1);
        check_done("f5");
        chk("f5_err", frame_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
